issue_scheduler: RTL

In-order issue scheduler between the decode stage and the execution units. It holds a register scoreboard of outstanding writes and checks RAW, WAW and unit-busy hazards for the instruction held in the decode output registers. It issues that instruction to its unit and drives decode's `allow_advance`. It also provides a drain handshake so trap and context-switch logic can quiesce the pipeline.

---
 rtl/sched_pkg.sv | 25 ++
 rtl/issue_scheduler_if.sv | 33 +++
 rtl/sched_scoreboard.sv | 57 +++++
 rtl/issue_scheduler.sv | 82 ++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared constants, FSM encoding and unit indices for the issue scheduler.
package sched_pkg;

  localparam int NREGS   = 64;
  localparam int REG_W   = 6;
  localparam int NUNITS  = 8;
  localparam int UNIT_W  = 3;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_IDLE  = 2'd2
  } state_e;

  localparam logic [UNIT_W-1:0] UNIT_ALU0 = 3'd0;
  localparam logic [UNIT_W-1:0] UNIT_ALU1 = 3'd1;
  localparam logic [UNIT_W-1:0] UNIT_MUL  = 3'd2;
  localparam logic [UNIT_W-1:0] UNIT_DIV  = 3'd3;
  localparam logic [UNIT_W-1:0] UNIT_LSU  = 3'd4;
  localparam logic [UNIT_W-1:0] UNIT_BRU  = 3'd5;
  localparam logic [UNIT_W-1:0] UNIT_FPU  = 3'd6;
  localparam logic [UNIT_W-1:0] UNIT_CSR  = 3'd7;

endpackage

// File: rtl/issue_scheduler_if.sv
// Decode/writeback/drain signals between the pipeline and the issue scheduler.
interface issue_scheduler_if;
  import sched_pkg::*;

  logic                 dec_valid;
  logic [UNIT_W-1:0]    dec_unit;
  logic [REG_W-1:0]     dec_rs1, dec_rs2, dec_rd, dec_rd2;
  logic                 dec_wr_rd, dec_wr_rd2;
  logic                 flush;
  logic [NUNITS-1:0]    unit_busy;
  logic [1:0]           wb_valid;
  logic [REG_W-1:0]     wb_rn0, wb_rn1;
  logic                 drain_req;
  logic                 issue_valid;
  logic [UNIT_W-1:0]    issue_unit;
  logic                 allow_advance;
  logic                 drain_ack;
  logic [STALL_W-1:0]   stall_cnt;
  logic                 sb_err;

  modport master (
    output dec_valid, dec_unit, dec_rs1, dec_rs2, dec_rd, dec_rd2,
           dec_wr_rd, dec_wr_rd2, flush, unit_busy, wb_valid, wb_rn0, wb_rn1, drain_req,
    input  issue_valid, issue_unit, allow_advance, drain_ack, stall_cnt, sb_err
  );

  modport slave (
    input  dec_valid, dec_unit, dec_rs1, dec_rs2, dec_rd, dec_rd2,
           dec_wr_rd, dec_wr_rd2, flush, unit_busy, wb_valid, wb_rn0, wb_rn1, drain_req,
    output issue_valid, issue_unit, allow_advance, drain_ack, stall_cnt, sb_err
  );

endinterface

// File: rtl/sched_scoreboard.sv
// Pending-write scoreboard: writeback clears bypass into eff_pending, issue sets win over clears.
// Flags a sticky error on writeback to register 0 or to a register with nothing outstanding.
module sched_scoreboard
  import sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_i,
  input  logic               wr_rd_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic               wr_rd2_i,
  input  logic [REG_W-1:0]   rd2_i,
  input  logic [1:0]         wb_valid_i,
  input  logic [REG_W-1:0]   wb_rn0_i,
  input  logic [REG_W-1:0]   wb_rn1_i,
  output logic [NREGS-1:0]   eff_pending_o,
  output logic               sb_err_o
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] wb_clear, set_mask;
  logic             sb_err_q, sb_err_d;
  logic             err0, err1;

  always_comb begin
    wb_clear = '0;
    if (wb_valid_i[0]) wb_clear[wb_rn0_i] = 1'b1;
    if (wb_valid_i[1]) wb_clear[wb_rn1_i] = 1'b1;

    set_mask = '0;
    if (issue_i && wr_rd_i)  set_mask[rd_i]  = 1'b1;
    if (issue_i && wr_rd2_i) set_mask[rd2_i] = 1'b1;
    set_mask[0] = 1'b0;

    pending_d    = (pending_q & ~wb_clear) | set_mask;
    pending_d[0] = 1'b0;
  end

  assign eff_pending_o = pending_q & ~wb_clear;

  // Judged against the registered bits only; a same-cycle issue does not excuse the writeback.
  assign err0     = wb_valid_i[0] && ((wb_rn0_i == '0) || !pending_q[wb_rn0_i]);
  assign err1     = wb_valid_i[1] && ((wb_rn1_i == '0) || !pending_q[wb_rn1_i]);
  assign sb_err_d = sb_err_q | err0 | err1;
  assign sb_err_o = sb_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      sb_err_q  <= sb_err_d;
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order issue: hazard check against the scoreboard, drain FSM and saturating stall counter.
// Issue, unit and allow_advance are combinational from registered state and current inputs.
module issue_scheduler
  import sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  issue_scheduler_if.slave bus
);

  logic [NREGS-1:0]   eff_pending;
  logic               sb_err;
  logic               hazard, run_ok, issue, stall_evt, quiet, drain_ack;
  state_e             state_q, state_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  sched_scoreboard u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_i       (issue),
    .wr_rd_i       (bus.dec_wr_rd),
    .rd_i          (bus.dec_rd),
    .wr_rd2_i      (bus.dec_wr_rd2),
    .rd2_i         (bus.dec_rd2),
    .wb_valid_i    (bus.wb_valid),
    .wb_rn0_i      (bus.wb_rn0),
    .wb_rn1_i      (bus.wb_rn1),
    .eff_pending_o (eff_pending),
    .sb_err_o      (sb_err)
  );

  assign hazard = eff_pending[bus.dec_rs1] | eff_pending[bus.dec_rs2]
                | (bus.dec_wr_rd  & eff_pending[bus.dec_rd])
                | (bus.dec_wr_rd2 & eff_pending[bus.dec_rd2])
                | bus.unit_busy[bus.dec_unit];

  // Quiescence uses the bypassed view so a final writeback completes the drain in its own cycle.
  assign quiet = (eff_pending == '0) && (bus.unit_busy == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (bus.drain_req) state_d = S_DRAIN;
      S_DRAIN: if (!bus.drain_req) state_d = S_RUN;
               else if (quiet)     state_d = S_IDLE;
      S_IDLE:  if (!bus.drain_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    run_ok    = 1'b0;
    drain_ack = 1'b0;
    case (state_q)
      S_RUN:   run_ok    = !bus.drain_req;
      S_IDLE:  drain_ack = 1'b1;
      default: ;
    endcase
  end

  assign issue     = bus.dec_valid & ~bus.flush & ~hazard & run_ok;
  assign stall_evt = bus.dec_valid & ~bus.flush & ~issue;
  assign stall_d   = (stall_evt && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.issue_valid   = issue;
  assign bus.issue_unit    = issue ? bus.dec_unit : '0;
  assign bus.allow_advance = ~bus.dec_valid | bus.flush | issue;
  assign bus.drain_ack     = drain_ack;
  assign bus.stall_cnt     = stall_q;
  assign bus.sb_err        = sb_err;

endmodule
